// File: rtl/rns_mod7_pkg.sv
// Shared mod-7 residue types and thermometer-code helpers for the RNS datapath.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
package rns_mod7_pkg;

    localparam int MOD7  = 7;
    localparam int TC7_W = 6;

    typedef logic [TC7_W-1:0] tc7_t;
    typedef logic [2:0]       res7_t;

    // Registered result payload, excluding the requester id whose width is parameter-dependent.
    typedef struct packed {
        tc7_t  tc;
        res7_t bin;
        logic  err;
    } res7_pkt_t;

    // Legal codes are a contiguous run of ones from the LSB: adding one must carry out of the whole run.
    function automatic logic tc7_is_legal(input tc7_t v);
        tc7_t nxt;
        nxt = v + 1'b1;
        return ((v & nxt) == '0);
    endfunction

    // Illegal codes decode to 0 so the adder still produces a defined result.
    function automatic res7_t tc7_to_bin(input tc7_t v);
        res7_t cnt;
        cnt = '0;
        if (tc7_is_legal(v)) begin
            for (int i = 0; i < TC7_W; i++) begin
                cnt = cnt + res7_t'(v[i]);
            end
        end
        return cnt;
    endfunction

    // Value s becomes s ones from the LSB.
    function automatic tc7_t bin_to_tc7(input res7_t s);
        tc7_t t;
        t = '0;
        for (int i = 0; i < TC7_W; i++) begin
            t[i] = (res7_t'(i) < s);
        end
        return t;
    endfunction

endpackage

// File: rtl/rns_mod7_add_arbiter_tc7_mod_add.sv
// Combinational modulo-7 adder on thermometer-coded residues, flagging illegal operand codes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the instantiating stage decides when the result is captured.
module tc7_mod_add
    import rns_mod7_pkg::*;
(
    input  tc7_t  a,
    input  tc7_t  b,
    output tc7_t  sum_tc,
    output res7_t sum_bin,
    output logic  err
);

    res7_t a_bin;
    res7_t b_bin;

    // Decode both operands, then reduce a+b into 0..6 without widening: a+b>=7 exactly when a >= 7-b.
    always_comb begin
        a_bin = tc7_to_bin(a);
        b_bin = tc7_to_bin(b);
        if (a_bin >= (3'(MOD7) - b_bin)) begin
            sum_bin = a_bin - (3'(MOD7) - b_bin);
        end else begin
            sum_bin = a_bin + b_bin;
        end
        sum_tc = bin_to_tc7(sum_bin);
        err    = !tc7_is_legal(a) || !tc7_is_legal(b);
    end

endmodule

// File: rtl/rns_mod7_add_arbiter.sv
// Round-robin shares one mod-7 thermometer adder among NUM_REQ requesters, registered result with a done counter.
// Latency: 1 cycle from grant to res_valid.
// Backpressure: grants only when the result register is empty or being popped; req_ready is all-zero otherwise.
module rns_mod7_add_arbiter
    import rns_mod7_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*6-1:0]   req_a,
    input  logic [NUM_REQ*6-1:0]   req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [5:0]             res_sum_tc,
    output logic [2:0]             res_sum_bin,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_err,
    output logic [CNT_W-1:0]       ops_done
);

    logic [ID_W-1:0] ptr;
    logic            can_load;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W:0]   cand;
    tc7_t            a_sel;
    tc7_t            b_sel;
    res7_pkt_t       add_pkt;
    res7_pkt_t       res_q;

    // The result slot is free when empty or when its occupant leaves this cycle.
    assign can_load = !res_valid || res_ready;

    // First valid requester at or after ptr, wrapping; nothing is granted while the slot is busy.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (can_load) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = {1'b0, ptr} + (ID_W+1)'(i);
                if (cand >= (ID_W+1)'(NUM_REQ)) begin
                    cand = cand - (ID_W+1)'(NUM_REQ);
                end
                if (!gnt_vld && req_valid[cand[ID_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = cand[ID_W-1:0];
                end
            end
        end
    end

    // One-hot accept toward the granted requester only.
    always_comb begin
        req_ready = '0;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // The granted requester's operands feed the single shared adder.
    assign a_sel = req_a[TC7_W*gnt_id +: TC7_W];
    assign b_sel = req_b[TC7_W*gnt_id +: TC7_W];

    tc7_mod_add u_add (
        .a       (a_sel),
        .b       (b_sel),
        .sum_tc  (add_pkt.tc),
        .sum_bin (add_pkt.bin),
        .err     (add_pkt.err)
    );

    // Round-robin pointer moves just past the requester that won.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Result register: a grant overwrites (even while popping); a pop without a grant empties it; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_q     <= '0;
            res_id    <= '0;
        end else if (gnt_vld) begin
            res_valid <= 1'b1;
            res_q     <= add_pkt;
            res_id    <= gnt_id;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign res_sum_tc  = res_q.tc;
    assign res_sum_bin = res_q.bin;
    assign res_err     = res_q.err;

    // Count results taken downstream, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (res_valid && res_ready && (ops_done != '1)) begin
            ops_done <= ops_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_rns_mod7_add_arbiter.sv
// Self-checking bench: directed literal cases plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: res_ready is driven both directed and randomly.
module tb_rns_mod7_add_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*6-1:0] req_a;
    logic [NREQ*6-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [5:0]      res_sum_tc;
    logic [2:0]      res_sum_bin;
    logic [1:0]      res_id;
    logic            res_err;
    logic [CW-1:0]   ops_done;

    int checks;
    int failures;

    // Behavioural model state
    logic            m_valid;
    logic [5:0]      m_tc;
    logic [2:0]      m_bin;
    logic [1:0]      m_id;
    logic            m_err;
    int              m_ops;
    int              m_ptr;
    logic [NREQ-1:0] m_ready;

    rns_mod7_add_arbiter #(.NUM_REQ(NREQ), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum_tc  (res_sum_tc),
        .res_sum_bin (res_sum_bin),
        .res_id      (res_id),
        .res_err     (res_err),
        .ops_done    (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] v);
        return (v == 6'd0 || v == 6'd1 || v == 6'd3 || v == 6'd7 ||
                v == 6'd15 || v == 6'd31 || v == 6'd63);
    endfunction

    function automatic int tval(input logic [5:0] v);
        if (legal(v)) return $countones(v);
        return 0;
    endfunction

    function automatic logic [5:0] rnd_code();
        int k;
        if ($urandom_range(0, 4) == 0) return 6'($urandom);
        k = $urandom_range(0, 6);
        return 6'((1 << k) - 1);
    endfunction

    task automatic setreq(input int i, input logic [5:0] a, input logic [5:0] b);
        req_a[6*i +: 6] = a;
        req_b[6*i +: 6] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model compare on every falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        logic       can;
        logic       gok;
        int         g;
        int         s;
        logic [5:0] a;
        logic [5:0] b;
        if (!rst_n) begin
            m_valid = 1'b0; m_tc = '0; m_bin = '0; m_id = '0; m_err = 1'b0;
            m_ops = 0; m_ptr = 0;
        end
        can = !m_valid || res_ready;
        gok = 1'b0;
        g = 0;
        m_ready = '0;
        if (can) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!gok && req_valid[(m_ptr + k) % NREQ]) begin
                    gok = 1'b1;
                    g = (m_ptr + k) % NREQ;
                end
            end
        end
        if (gok) m_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("ops_done", 32'(ops_done), 32'(m_ops));
        if (!rst_n || m_valid) begin
            chk("res_sum_tc", 32'(res_sum_tc), 32'(m_tc));
            chk("res_sum_bin", 32'(res_sum_bin), 32'(m_bin));
            chk("res_id", 32'(res_id), 32'(m_id));
            chk("res_err", 32'(res_err), 32'(m_err));
        end
        if (rst_n) begin
            if (m_valid && res_ready && m_ops < CMAX) m_ops++;
            if (gok) begin
                a = req_a[6*g +: 6];
                b = req_b[6*g +: 6];
                s = (tval(a) + tval(b)) % 7;
                m_bin   = 3'(s);
                m_tc    = 6'((1 << s) - 1);
                m_err   = !legal(a) || !legal(b);
                m_id    = 2'(g);
                m_valid = 1'b1;
                m_ptr   = (g + 1) % NREQ;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    int exp_ids[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        logic [NREQ-1:0] acc;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        m_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_ops", 32'(ops_done), 32'd0);
        chk("rst_tc", 32'(res_sum_tc), 32'd0);
        chk("rst_bin", 32'(res_sum_bin), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        res_ready = 1'b1;

        // 3 + 5 = 8 -> 1
        setreq(0, 6'b000111, 6'b011111);
        req_valid = 4'b0001;
        #1 chk("t1_ready", 32'(req_ready), 32'b0001);
        step();
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_bin", 32'(res_sum_bin), 32'b001);
        chk("t1_tc", 32'(res_sum_tc), 32'b000001);
        chk("t1_id", 32'(res_id), 32'd0);
        chk("t1_err", 32'(res_err), 32'd0);

        // 6 + 6 = 12 -> 5, then 0 + 0
        setreq(2, 6'b111111, 6'b111111);
        req_valid = 4'b0100;
        step();
        chk("t2_bin", 32'(res_sum_bin), 32'b101);
        chk("t2_tc", 32'(res_sum_tc), 32'b011111);
        chk("t2_id", 32'(res_id), 32'd2);
        setreq(2, 6'b000000, 6'b000000);
        step();
        chk("t2z_bin", 32'(res_sum_bin), 32'd0);
        chk("t2z_tc", 32'(res_sum_tc), 32'd0);
        chk("t2z_ops", 32'(ops_done), 32'd2);

        // Grant req3 to bring the pointer back to 0
        setreq(3, 6'b000001, 6'b000011);
        req_valid = 4'b1000;
        step();
        chk("t3pre_id", 32'(res_id), 32'd3);
        chk("t3pre_bin", 32'(res_sum_bin), 32'd3);

        // All valid, continuous pop: rotation 0,1,2,3,0,1
        for (int i = 0; i < NREQ; i++) setreq(i, 6'b000001, 6'((1 << i) - 1));
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_id", 32'(res_id), 32'(exp_ids[k]));
            chk("t3_ops", 32'(ops_done), 32'(4 + k));
        end

        // Stall downstream for 3 cycles
        res_ready = 1'b0;
        #1 chk("t4_ready0", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_id", 32'(res_id), 32'd1);
            chk("t4_hold_bin", 32'(res_sum_bin), 32'd2);
            chk("t4_hold_ops", 32'(ops_done), 32'd9);
            chk("t4_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        #1 chk("t4_regrant", 32'(req_ready), 32'b0100);
        step();
        chk("t4_id", 32'(res_id), 32'd2);
        chk("t4_ops", 32'(ops_done), 32'd10);
        req_valid = '0;

        // Illegal operand treated as 0
        setreq(0, 6'b000101, 6'b000011);
        req_valid = 4'b0001;
        step();
        chk("t5_bin", 32'(res_sum_bin), 32'b010);
        chk("t5_err", 32'(res_err), 32'd1);
        setreq(1, 6'b000001, 6'b000001);
        req_valid = 4'b0010;
        step();
        chk("t5_bin2", 32'(res_sum_bin), 32'b010);
        chk("t5_err2", 32'(res_err), 32'd0);

        // Asynchronous reset while a result is pending
        setreq(0, 6'b000001, 6'b000001);
        req_valid = 4'b0001;
        step();
        chk("t6_pre_valid", 32'(res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(res_valid), 32'd0);
        chk("t6_ops", 32'(ops_done), 32'd0);
        chk("t6_bin", 32'(res_sum_bin), 32'd0);
        chk("t6_tc", 32'(res_sum_tc), 32'd0);
        chk("t6_id", 32'(res_id), 32'd0);
        chk("t6_err", 32'(res_err), 32'd0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        setreq(1, 6'b000111, 6'b000111);
        setreq(3, 6'b000001, 6'b000001);
        req_valid = 4'b1010;
        #1 chk("t6_ready", 32'(req_ready), 32'b0010);
        step();
        chk("t6_id", 32'(res_id), 32'd1);
        chk("t6_bin", 32'(res_sum_bin), 32'd6);
        chk("t6_tc", 32'(res_sum_tc), 32'b111111);

        // Randomized traffic; operands change only when idle or just accepted
        for (int c = 0; c < 3000; c++) begin
            acc = req_valid & m_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    setreq(i, rnd_code(), rnd_code());
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
